div_share_arbiter: RTL
======================

Name: div_share_arbiter

Overview:
- Shares one pipelined unsigned array divider among NUM_REQ requesters.
- Arbitrates requests round-robin under per-requester outstanding-credit limits and issues at most one operation per cycle into the divider.
- Carries a requester tag alongside each operation through a shadow pipeline of the divider's latency, then returns each quotient/remainder to its originating requester.
- Sits between requester-side logic and the divider instance; the divider has no stall and sees continuous-valid semantics.

Parameters:
- DATAWIDTH, 8, operand/result width; must match the divider.
- NUM_REQ, 4, number of requesters, 2..8.
- DIV_LATENCY, 9, cycles from div_i_valid to div_o_valid; equals divider NUM_PIPELINE_STAGES, range 1..DATAWIDTH+1.
- MAX_OUTSTANDING, 4, per-requester in-flight cap, 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; low blocks new grants, in-flight ops drain
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*DATAWIDTH  dividends, requester i at [i*DATAWIDTH +: DATAWIDTH]
- req_b  in  NUM_REQ*DATAWIDTH  divisors, same packing
- div_i_valid  out  1  issue valid to divider
- div_a  out  DATAWIDTH  dividend to divider
- div_b  out  DATAWIDTH  divisor to divider
- div_o_valid  in  1  divider result valid
- div_q  in  DATAWIDTH  divider quotient
- div_r  in  DATAWIDTH  divider remainder
- rsp_valid  out  NUM_REQ  one-hot response strobe; no backpressure
- rsp_q  out  DATAWIDTH  quotient of the current response
- rsp_r  out  DATAWIDTH  remainder of the current response
- rsp_dz  out  1  current response had divisor == 0
- idle  out  1  no credits in use and tag pipe empty
- err_sync  out  1  sticky; tag pipe and divider valid disagreed

Behaviour:
- Reset (async, rst_n=0): all outputs are 0 except idle=1. RR pointer is 0, credit counters are 0, tag pipe is cleared, err_sync is cleared. Any divider results arriving after reset are not tagged.
- Eligibility: eligible[i] = req_valid[i] & (cnt[i] < MAX_OUTSTANDING) & en.
- Arbitration:
  - Combinational round-robin starting at ptr; grant = first eligible index scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - req_ready = grant. The handshake occurs in cycle T when req_valid[i] & req_ready[i].
  - On a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Issue register: in T+1, div_i_valid=1 with div_a/div_b holding the granted operands. Without a grant, div_i_valid=0 and div_a/div_b hold their previous values.
- Tag pipe: DIV_LATENCY entries of {valid, id[clog2(NUM_REQ)-1:0], dz}, entered alongside the issue register. The tail aligns with div_o_valid (T+1+DIV_LATENCY). dz = (req_b == 0) at grant.
- Response register: in cycle T+2+DIV_LATENCY:
  - rsp_valid[id] = 1 for one cycle; rsp_q/rsp_r = div_q/div_r; rsp_dz = dz.
  - Divide-by-zero data is passed through unmodified; consumers use rsp_dz.
  - rsp_q/rsp_r hold their values when rsp_valid = 0.
- Credits:
  - cnt[i] increments at the handshake and decrements when rsp_valid[i] is asserted.
  - Handshake and response for the same i in the same cycle leave cnt unchanged.
  - A requester at MAX_OUTSTANDING is skipped by arbitration and does not hold the pointer.
- Throughput: one grant per cycle sustained; total latency from handshake to response = DIV_LATENCY+2.
- Ordering: responses per requester are returned in issue order (fixed-latency pipe).
- err_sync: set when the tail valid != div_o_valid; cleared only by reset. On mismatch, rsp_valid is not asserted.
- idle = (all cnt == 0) & no valid entry in the tag pipe, issue register or response register.
- en deasserted mid-stream: no new grants; in-flight ops complete normally; ptr holds.
- Requester drops req_valid without a handshake: legal, no state change.

Test Plan:
- Single op: requester 2 issues A=100, B=7 at cycle 10 -> div_i_valid at 11, rsp_valid=4'b0100 at 10+9+2=21, rsp_q=14, rsp_r=2, rsp_dz=0, idle=1 at 22.
- Round-robin fairness: all four req_valid held high for 8 cycles with ptr=0 -> grants ordered 0,1,2,3,0,1,2,3; responses return in the same order on consecutive cycles.
- Credit cap: MAX_OUTSTANDING=2, only requester 1 requesting continuously -> two grants, then req_ready[1]=0 until the first response; a new grant follows in the same cycle as rsp_valid[1].
- Divide by zero: requester 0 issues A=55, B=0 -> rsp_valid[0] after DIV_LATENCY+2 with rsp_dz=1; cnt[0] returns to 0.
- en and reset: en=0 with pending requests -> no req_ready and in-flight ops drain to idle=1. Assert rst_n=0 with 5 ops in flight -> outputs cleared immediately and cnts 0; divider results arriving later set err_sync=1 with no rsp_valid.
- Sync fault: force div_o_valid=1 for one cycle with an empty tag pipe -> err_sync=1 sticky, rsp_valid stays 0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin, credit-limited front end that shares one fixed-latency
// pipelined divider among NUM_REQ requesters. A shadow tag pipe carries the
// requester id and a divide-by-zero flag alongside each operation, so every
// result goes back to the requester that issued it.
//
// Handshake: requester i transfers an operation in any cycle where
// req_valid[i] & req_ready[i] are both high. req_ready is one-hot or zero.
// The requester may drop req_valid without a transfer. Responses have no
// backpressure: rsp_valid is a one-cycle strobe.
module div_share_arbiter #(
  parameter int DATAWIDTH       = 8,
  parameter int NUM_REQ         = 4,
  parameter int DIV_LATENCY     = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
  output logic                           div_i_valid,
  output logic [DATAWIDTH-1:0]           div_a,
  output logic [DATAWIDTH-1:0]           div_b,
  input  logic                           div_o_valid,
  input  logic [DATAWIDTH-1:0]           div_q,
  input  logic [DATAWIDTH-1:0]           div_r,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATAWIDTH-1:0]           rsp_q,
  output logic [DATAWIDTH-1:0]           rsp_r,
  output logic                           rsp_dz,
  output logic                           idle,
  output logic                           err_sync
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Credit counters are sized for the largest allowed cap (15).
  localparam int CW  = 4;

  logic [IDW-1:0]       ptr;
  logic [CW-1:0]        cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic                 gnt_found;
  logic [IDW-1:0]       gnt_id;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_b;

  // Tag travelling with the issue register, then the shadow pipe proper.
  logic [IDW-1:0]         iss_id;
  logic                   iss_dz;
  logic [DIV_LATENCY-1:0] tp_v;
  logic [DIV_LATENCY-1:0] tp_dz;
  logic [IDW-1:0]         tp_id [DIV_LATENCY];

  logic                 tail_v;
  logic [IDW-1:0]       tail_id;
  logic                 tail_dz;
  logic                 rsp_fire;
  logic                 mismatch;
  logic [NUM_REQ-1:0]   rsp_dec;
  logic                 any_cnt;

  // Modular walk from the round-robin pointer.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Eligibility: valid, under the credit cap, and globally enabled.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & en & (cnt[i] < CW'(MAX_OUTSTANDING));
    end
  end

  // Round-robin pick: first eligible index starting at ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && eligible[wrap_idx(ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = wrap_idx(ptr, k);
      end
    end
    if (gnt_found) grant[gnt_id] = 1'b1;
  end

  assign req_ready = grant;
  assign sel_a     = req_a[gnt_id*DATAWIDTH +: DATAWIDTH];
  assign sel_b     = req_b[gnt_id*DATAWIDTH +: DATAWIDTH];

  // Pointer advances past the winner; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_found) begin
      ptr <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Issue register: operands hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_i_valid <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      iss_id      <= '0;
      iss_dz      <= 1'b0;
    end else begin
      div_i_valid <= gnt_found;
      if (gnt_found) begin
        div_a  <= sel_a;
        div_b  <= sel_b;
        iss_id <= gnt_id;
        iss_dz <= (sel_b == '0);
      end
    end
  end

  // Shadow tag pipe: tail lines up with the divider's result valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_v  <= '0;
      tp_dz <= '0;
      for (int k = 0; k < DIV_LATENCY; k++) tp_id[k] <= '0;
    end else begin
      tp_v[0]  <= div_i_valid;
      tp_dz[0] <= iss_dz;
      tp_id[0] <= iss_id;
      for (int k = 1; k < DIV_LATENCY; k++) begin
        tp_v[k]  <= tp_v[k-1];
        tp_dz[k] <= tp_dz[k-1];
        tp_id[k] <= tp_id[k-1];
      end
    end
  end

  assign tail_v   = tp_v[DIV_LATENCY-1];
  assign tail_id  = tp_id[DIV_LATENCY-1];
  assign tail_dz  = tp_dz[DIV_LATENCY-1];
  assign rsp_fire = tail_v & div_o_valid;
  assign mismatch = tail_v ^ div_o_valid;

  // One-hot decode of the requester being answered this cycle.
  always_comb begin
    rsp_dec = '0;
    if (rsp_fire) rsp_dec[tail_id] = 1'b1;
  end

  // Response register and sticky tag/divider disagreement flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dz    <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      rsp_valid <= rsp_dec;
      if (rsp_fire) begin
        rsp_q  <= div_q;
        rsp_r  <= div_r;
        rsp_dz <= tail_dz;
      end
      if (mismatch) err_sync <= 1'b1;
    end
  end

  // Credits: +1 at handshake, -1 as the response strobe is registered,
  // so a freed credit is usable in the same cycle rsp_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], rsp_dec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Idle: no credits held and nothing in any pipeline register.
  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) any_cnt = any_cnt | (cnt[i] != '0);
  end

  assign idle = ~any_cnt & ~div_i_valid & ~(|tp_v) & ~(|rsp_valid);

endmodule
